// File: rtl/mul3_pkg.sv
// Shared types and constants for the multiply-by-3 reconstruction block.
// Holds the FSM state type, the default operand width and the counter-width helper.
package mul3_pkg;

  localparam int unsigned MUL3_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul3_state_t;

  // Bit counter must index result bits 0..width+1.
  function automatic int unsigned mul3_cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/mul3_bitslice.sv
// One bit of the serial 3*q + r sum: adds q[k], q[k-1], r[k] and a 2-bit carry.
// The sum never exceeds 5, so a 2-bit carry-out is always sufficient.
module mul3_bitslice (
  input  logic       q_k,
  input  logic       q_km1,
  input  logic       r_k,
  input  logic [1:0] carry_in,
  output logic       sum_bit,
  output logic [1:0] carry_out
);

  logic [2:0] s;

  always_comb begin
    s         = {2'b00, q_k} + {2'b00, q_km1} + {2'b00, r_k} + {1'b0, carry_in};
    sum_bit   = s[0];
    carry_out = s[2:1];
  end

endmodule

// File: rtl/mul_by_3_seq.sv
// Bit-serial reconstruction of a = 3*q + r (inverse of div_by_3), one bit per cycle.
// Optional macro MUL3_REM_CHECK_EN flags an illegal remainder r == 3 on err.
module mul_by_3_seq
  import mul3_pkg::*;
#(
  parameter int unsigned WIDTH = MUL3_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned CW = mul3_cnt_width(WIDTH);
  localparam int unsigned RW = WIDTH + 2;
  localparam logic [CW-1:0] K_LAST = CW'(WIDTH + 1);

  mul3_state_t      state;
  mul3_state_t      state_nxt;

  logic [WIDTH-1:0] q_reg;
  logic [1:0]       r_reg;
  logic [CW-1:0]    k;
  logic [1:0]       carry;
  logic [RW-1:0]    result;

  logic             accept;
  logic             release_out;
  logic             last_bit;

  logic [WIDTH+2:0] q_ext;
  logic [1:0]       q_pair;
  logic             q_k;
  logic             q_km1;
  logic             r_k;
  logic             sum_bit;
  logic [1:0]       carry_nxt;

  assign in_ready    = (state == IDLE) && !rst;
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign last_bit    = (k == K_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)      state_nxt = RUN;
      RUN:     if (last_bit)    state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // q padded with a zero below (q[-1]) and two zeros above (q[WIDTH], q[WIDTH+1]);
  // shifting by k leaves q[k-1] in bit 0 and q[k] in bit 1.
  always_comb begin
    q_ext  = {2'b00, q_reg, 1'b0};
    q_pair = 2'(q_ext >> k);
    q_k    = q_pair[1];
    q_km1  = q_pair[0];
    r_k    = 1'b0;
    if (k == '0)            r_k = r_reg[0];
    else if (k == CW'(1))   r_k = r_reg[1];
  end

  mul3_bitslice u_bitslice (
    .q_k       (q_k),
    .q_km1     (q_km1),
    .r_k       (r_k),
    .carry_in  (carry),
    .sum_bit   (sum_bit),
    .carry_out (carry_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg  <= '0;
      r_reg  <= '0;
      k      <= '0;
      carry  <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        q_reg  <= q;
        r_reg  <= r;
        k      <= '0;
        carry  <= '0;
        result <= '0;
      end else if (state == RUN) begin
        result <= result | (RW'(sum_bit) << k);
        carry  <= carry_nxt;
        k      <= k + CW'(1);
      end
    end
  end

  assign p   = out_valid ? result[WIDTH-1:0] : '0;
  assign ovf = out_valid && (|result[RW-1:WIDTH]);

`ifdef MUL3_REM_CHECK_EN
  assign err = out_valid && (r_reg == 2'd3);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_by_3_seq.sv
// Directed self-checking bench for mul_by_3_seq: vector table plus backpressure/reset sequences.
// Expected err follows MUL3_REM_CHECK_EN as defined for the build.
module tb_mul_by_3_seq;

  localparam int unsigned W = 16;
`ifdef MUL3_REM_CHECK_EN
  localparam bit REM_CHECK = 1'b1;
`else
  localparam bit REM_CHECK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] q = '0;
  logic [1:0]   r = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] p;
  logic         ovf;
  logic         err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mul_by_3_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [1:0]   r;
    logic [W-1:0] p;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] qi, input logic [1:0] ri, input logic [W-1:0] ep,
                       input logic eo, input string tag);
    int unsigned n;
    logic ee;
    ee = REM_CHECK && (ri == 2'd3);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    q = qi; r = ri; in_valid = 1'b1;
    tick();
    // scramble operands during RUN; they must be ignored
    in_valid = 1'b0; q = ~qi; r = ~ri;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk({tag, "_latency"}, n, 32'd18);
    chk({tag, "_p"}, 32'(p), 32'(ep));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ir_back"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    int unsigned n;
    vecs[0]  = '{q: 16'd7,     r: 2'd0, p: 16'd21,    ovf: 1'b0};
    vecs[1]  = '{q: 16'd2,     r: 2'd2, p: 16'd8,     ovf: 1'b0};
    vecs[2]  = '{q: 16'd0,     r: 2'd0, p: 16'd0,     ovf: 1'b0};
    vecs[3]  = '{q: 16'd0,     r: 2'd1, p: 16'd1,     ovf: 1'b0};
    vecs[4]  = '{q: 16'd21845, r: 2'd1, p: 16'd0,     ovf: 1'b1};
    vecs[5]  = '{q: 16'd65535, r: 2'd2, p: 16'd65535, ovf: 1'b1};
    vecs[6]  = '{q: 16'd21845, r: 2'd0, p: 16'd65535, ovf: 1'b0};
    vecs[7]  = '{q: 16'd1000,  r: 2'd2, p: 16'd3002,  ovf: 1'b0};
    vecs[8]  = '{q: 16'd5,     r: 2'd3, p: 16'd18,    ovf: 1'b0};
    vecs[9]  = '{q: 16'd65535, r: 2'd3, p: 16'd0,     ovf: 1'b1};
    vecs[10] = '{q: 16'd0,     r: 2'd3, p: 16'd3,     ovf: 1'b0};
    vecs[11] = '{q: 16'd43690, r: 2'd1, p: 16'd65535, ovf: 1'b1};

    // reset state
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i])
      do_op(vecs[i].q, vecs[i].r, vecs[i].p, vecs[i].ovf, $sformatf("vec%0d", i));

    // backpressure: result held while out_ready low, new input refused
    q = 16'd1; r = 2'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("bp_latency", n, 32'd18);
    for (int unsigned c = 0; c < 10; c++) begin
      in_valid = 1'b1; q = 16'h1234; r = 2'd1;
      tick();
      chk($sformatf("bp_p_%0d", c), 32'(p), 32'd3);
      chk($sformatf("bp_ov_%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_ir_%0d", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ir", 32'(in_ready), 32'd1);

    // reset mid-RUN aborts with no result
    q = 16'd1234; r = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_p", 32'(p), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_release_ir", 32'(in_ready), 32'd1);
    n = 0;
    for (int unsigned c = 0; c < 25; c++) begin
      tick();
      if (out_valid) n++;
    end
    chk("mid_rst_no_result", n, 32'd0);
    do_op(16'd3, 2'd0, 16'd9, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
